// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: opcode encoding, start
// decode helpers and default busy-window lengths.
package mdu_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_mdu_start(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) ||
               (op == MDU_DIV)  || (op == MDU_DIVU);
    endfunction

    function automatic logic is_mdu_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Purely combinational 32x32 multiply and divide datapath producing the
// 64-bit HI/LO result and a divide-by-zero flag for div/divu.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div_by_zero
);

    logic               bZero;
    logic signed [63:0] prodS;
    logic        [63:0] prodU;
    logic signed [32:0] dividendS;
    logic signed [32:0] divisorS;
    logic signed [32:0] quotS;
    logic signed [32:0] remS;
    logic        [31:0] divisorU;
    logic        [31:0] quotU;
    logic        [31:0] remU;
    logic               unusedDivBits;

    // Signed divide runs at 33 bits so 0x80000000 / -1 yields +2^31 without
    // overflow; truncating to 32 bits then gives LO=0x80000000, HI=0.
    // A zero divisor is replaced by 1 only to keep the divider defined; the
    // result is discarded through div_by_zero.
    always_comb begin
        bZero       = (b == 32'd0);
        div_by_zero = is_mdu_div(op) && bZero;
        prodS       = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        prodU       = {32'd0, a} * {32'd0, b};
        dividendS   = $signed({a[31], a});
        divisorS    = bZero ? 33'sd1 : $signed({b[31], b});
        quotS       = dividendS / divisorS;
        remS        = dividendS % divisorS;
        divisorU    = bZero ? 32'd1 : b;
        quotU       = a / divisorU;
        remU        = a % divisorU;
        unusedDivBits = quotS[32] ^ remS[32];

        res_hi = 32'd0;
        res_lo = 32'd0;
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prodS;
            MDU_MULTU: {res_hi, res_lo} = prodU;
            MDU_DIV: begin
                res_hi = remS[31:0];
                res_lo = quotS[31:0];
            end
            MDU_DIVU: begin
                res_hi = remU;
                res_lo = quotU;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_hilo.sv
// E-stage multiply/divide unit: owns HI/LO, runs a fixed-length busy window
// per mult/div and commits the pending result when the window closes.
module mdu_hilo
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdu_out
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pendHi_q, pendHi_d;
    logic [31:0]   pendLo_q, pendLo_d;
    logic          suppress_q, suppress_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;

    logic [31:0] resHi;
    logic [31:0] resLo;
    logic        divByZero;

    mdu_arith u_arith (
        .op          (op),
        .a           (rs_val),
        .b           (rt_val),
        .res_hi      (resHi),
        .res_lo      (resLo),
        .div_by_zero (divByZero)
    );

    assign busy    = (state_q == ST_BUSY);
    assign start   = is_mdu_start(op) && !busy;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign mdu_out = (op == MDU_MFHI) ? hi_q :
                     (op == MDU_MFLO) ? lo_q : 32'd0;

    // Any op arriving while busy is dropped; a divide by zero still runs the
    // full window but never writes HI/LO.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pendHi_d   = pendHi_q;
        pendLo_d   = pendLo_q;
        suppress_d = suppress_q;
        hi_d       = hi_q;
        lo_d       = lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pendHi_d   = resHi;
                    pendLo_d   = resLo;
                    suppress_d = divByZero;
                    cnt_d      = is_mdu_div(op) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                    state_d    = ST_BUSY;
                end else if (op == MDU_MTHI) begin
                    hi_d = rs_val;
                end else if (op == MDU_MTLO) begin
                    lo_d = rs_val;
                end
            end
            default: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    if (!suppress_q) begin
                        hi_d = pendHi_q;
                        lo_d = pendLo_q;
                    end
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            pendHi_q   <= 32'd0;
            pendLo_q   <= 32'd0;
            suppress_q <= 1'b0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pendHi_q   <= pendHi_d;
            pendLo_q   <= pendLo_d;
            suppress_q <= suppress_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: busy-window timing, signed/unsigned results,
// divide by zero, reset abort and mthi/mfhi ordering.
module tb_mdu_hilo;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  op;
    logic [31:0] rsVal;
    logic [31:0] rtVal;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mduOut;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    mdu_hilo dut (
        .clk     (clk),
        .reset   (reset),
        .op      (op),
        .rs_val  (rsVal),
        .rt_val  (rtVal),
        .start   (start),
        .busy    (busy),
        .hi      (hi),
        .lo      (lo),
        .mdu_out (mduOut)
    );

    // A correct stall controller never presents an MDU op while busy.
    always @(negedge clk) begin
        if (!reset && busy && op != MDU_NONE) begin
            $display("[TB] FAIL op_during_busy: op=%0d busy=%b required op=0", op, busy);
            errorCount++;
        end
    end

    // Drives one cycle's inputs just after the rising edge, leaving time for
    // combinational outputs to settle before the caller checks them.
    task automatic applyStimulus(input logic [3:0] opIn, input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        op    = opIn;
        rsVal = a;
        rtVal = b;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        op = MDU_NONE; rsVal = 32'd0; rtVal = 32'd0;
        applyStimulus(MDU_NONE, 32'd0, 32'd0);
        applyStimulus(MDU_NONE, 32'd0, 32'd0);
        reset = 1'b0;
        checkCount++;
        if (busy !== 1'b0) begin $display("[TB] FAIL reset_busy: got %b want 0", busy); errorCount++; end
        checkCount++;
        if (hi !== 32'd0 || lo !== 32'd0) begin
            $display("[TB] FAIL reset_hilo: got hi=%h lo=%h want 0/0", hi, lo); errorCount++;
        end
        checkCount++;
        if (start !== 1'b0) begin $display("[TB] FAIL reset_start: got %b want 0", start); errorCount++; end
        op = MDU_MFHI; #1;
        checkCount++;
        if (mduOut !== 32'd0) begin $display("[TB] FAIL reset_mfhi: got %h want 0", mduOut); errorCount++; end
    endtask

    task automatic test_mult();
        applyStimulus(MDU_MULT, 32'hFFFFFFFE, 32'd3);
        checkCount++;
        if (start !== 1'b1 || busy !== 1'b0) begin
            $display("[TB] FAIL mult_c0: got start=%b busy=%b want 1/0", start, busy); errorCount++;
        end
        for (int c = 1; c <= 5; c++) begin
            applyStimulus(MDU_NONE, 32'd0, 32'd0);
            checkCount++;
            if (busy !== 1'b1 || start !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
                $display("[TB] FAIL mult_busy_c%0d: got busy=%b start=%b hi=%h lo=%h want 1/0/0/0",
                         c, busy, start, hi, lo); errorCount++;
            end
        end
        applyStimulus(MDU_NONE, 32'd0, 32'd0);
        checkCount++;
        if (busy !== 1'b0 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
            $display("[TB] FAIL mult_commit: got busy=%b hi=%h lo=%h want 0/ffffffff/fffffffa",
                     busy, hi, lo); errorCount++;
        end
    endtask

    task automatic test_multu();
        applyStimulus(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        for (int c = 1; c <= 5; c++) begin
            applyStimulus(MDU_NONE, 32'd0, 32'd0);
            checkCount++;
            if (busy !== 1'b1) begin $display("[TB] FAIL multu_busy_c%0d: got %b want 1", c, busy); errorCount++; end
        end
        applyStimulus(MDU_NONE, 32'd0, 32'd0);
        checkCount++;
        if (busy !== 1'b0 || hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
            $display("[TB] FAIL multu_commit: got busy=%b hi=%h lo=%h want 0/fffffffe/00000001",
                     busy, hi, lo); errorCount++;
        end
    endtask

    task automatic test_div();
        applyStimulus(MDU_DIV, 32'hFFFFFFF9, 32'd2);
        for (int c = 1; c <= 10; c++) begin
            applyStimulus(MDU_NONE, 32'd0, 32'd0);
            checkCount++;
            if (busy !== 1'b1 || hi !== 32'hFFFFFFFE) begin
                $display("[TB] FAIL div_busy_c%0d: got busy=%b hi=%h want 1/fffffffe", c, busy, hi); errorCount++;
            end
        end
        applyStimulus(MDU_NONE, 32'd0, 32'd0);
        checkCount++;
        if (busy !== 1'b0 || hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
            $display("[TB] FAIL div_commit: got busy=%b hi=%h lo=%h want 0/ffffffff/fffffffd",
                     busy, hi, lo); errorCount++;
        end
    endtask

    task automatic test_div_overflow();
        applyStimulus(MDU_DIV, 32'h80000000, 32'hFFFFFFFF);
        for (int c = 1; c <= 11; c++) applyStimulus(MDU_NONE, 32'd0, 32'd0);
        checkCount++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'h80000000) begin
            $display("[TB] FAIL div_overflow: got busy=%b hi=%h lo=%h want 0/00000000/80000000",
                     busy, hi, lo); errorCount++;
        end
    endtask

    task automatic test_divu_by_zero();
        applyStimulus(MDU_MTHI, 32'h1234, 32'd0);
        applyStimulus(MDU_MTLO, 32'h5678, 32'd0);
        applyStimulus(MDU_DIVU, 32'd99, 32'd0);
        checkCount++;
        if (start !== 1'b1) begin $display("[TB] FAIL divz_start: got %b want 1", start); errorCount++; end
        for (int c = 1; c <= 10; c++) begin
            applyStimulus(MDU_NONE, 32'd0, 32'd0);
            checkCount++;
            if (busy !== 1'b1) begin $display("[TB] FAIL divz_busy_c%0d: got %b want 1", c, busy); errorCount++; end
        end
        applyStimulus(MDU_MFHI, 32'd0, 32'd0);
        checkCount++;
        if (busy !== 1'b0 || hi !== 32'h1234 || lo !== 32'h5678) begin
            $display("[TB] FAIL divz_hilo: got busy=%b hi=%h lo=%h want 0/00001234/00005678",
                     busy, hi, lo); errorCount++;
        end
        checkCount++;
        if (mduOut !== 32'h1234) begin $display("[TB] FAIL divz_mfhi: got %h want 00001234", mduOut); errorCount++; end
        op = MDU_MFLO; #1;
        checkCount++;
        if (mduOut !== 32'h5678) begin $display("[TB] FAIL divz_mflo: got %h want 00005678", mduOut); errorCount++; end
    endtask

    task automatic test_reset_abort();
        applyStimulus(MDU_DIV, 32'd100, 32'd7);
        for (int c = 1; c <= 4; c++) applyStimulus(MDU_NONE, 32'd0, 32'd0);
        checkCount++;
        if (busy !== 1'b1) begin $display("[TB] FAIL abort_busy_c4: got %b want 1", busy); errorCount++; end
        reset = 1'b1;
        applyStimulus(MDU_NONE, 32'd0, 32'd0);
        reset = 1'b0;
        checkCount++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
            $display("[TB] FAIL abort_cleared: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo); errorCount++;
        end
        for (int c = 6; c <= 12; c++) begin
            applyStimulus(MDU_NONE, 32'd0, 32'd0);
            checkCount++;
            if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
                $display("[TB] FAIL abort_no_commit_c%0d: got busy=%b hi=%h lo=%h want 0/0/0",
                         c, busy, hi, lo); errorCount++;
            end
        end
    endtask

    task automatic test_mthi_mfhi();
        applyStimulus(MDU_MTHI, 32'h1111, 32'd0);
        applyStimulus(MDU_MTHI, 32'hAAAA, 32'd0);
        checkCount++;
        if (hi !== 32'h1111 || mduOut !== 32'd0 || start !== 1'b0) begin
            $display("[TB] FAIL mthi_same_cycle: got hi=%h out=%h start=%b want 00001111/0/0",
                     hi, mduOut, start); errorCount++;
        end
        applyStimulus(MDU_MFHI, 32'd0, 32'd0);
        checkCount++;
        if (mduOut !== 32'hAAAA) begin $display("[TB] FAIL mfhi_next: got %h want 0000aaaa", mduOut); errorCount++; end
        applyStimulus(MDU_MTLO, 32'h5555, 32'd0);
        applyStimulus(MDU_MFLO, 32'd0, 32'd0);
        checkCount++;
        if (mduOut !== 32'h5555 || hi !== 32'hAAAA) begin
            $display("[TB] FAIL mflo_next: got out=%h hi=%h want 00005555/0000aaaa", mduOut, hi); errorCount++;
        end
        applyStimulus(4'hF, 32'hDEAD, 32'd3);
        checkCount++;
        if (mduOut !== 32'd0 || start !== 1'b0) begin
            $display("[TB] FAIL undef_op: got out=%h start=%b want 0/0", mduOut, start); errorCount++;
        end
        applyStimulus(MDU_NONE, 32'd0, 32'd0);
        checkCount++;
        if (busy !== 1'b0 || hi !== 32'hAAAA || lo !== 32'h5555) begin
            $display("[TB] FAIL undef_no_effect: got busy=%b hi=%h lo=%h want 0/0000aaaa/00005555",
                     busy, hi, lo); errorCount++;
        end
    endtask

    task automatic test_back_to_back();
        applyStimulus(MDU_MULT, 32'd7, 32'd6);
        for (int c = 1; c <= 5; c++) applyStimulus(MDU_NONE, 32'd0, 32'd0);
        applyStimulus(MDU_MULTU, 32'd2, 32'd3);
        checkCount++;
        if (start !== 1'b1 || busy !== 1'b0 || lo !== 32'd42 || hi !== 32'd0) begin
            $display("[TB] FAIL b2b_first: got start=%b busy=%b hi=%h lo=%h want 1/0/0/0000002a",
                     start, busy, hi, lo); errorCount++;
        end
        for (int c = 1; c <= 5; c++) applyStimulus(MDU_NONE, 32'd0, 32'd0);
        applyStimulus(MDU_NONE, 32'd0, 32'd0);
        checkCount++;
        if (busy !== 1'b0 || lo !== 32'd6 || hi !== 32'd0) begin
            $display("[TB] FAIL b2b_second: got busy=%b hi=%h lo=%h want 0/0/00000006", busy, hi, lo); errorCount++;
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_div_overflow();
        test_divu_by_zero();
        test_reset_abort();
        test_mthi_mfhi();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
